// File: rtl/keypad_hex_scanner_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 hex keypad scanner.
//   state_t   - scanner FSM states
//   KEY_CLEAR - hex code of the '#' key
//   map()     - (row, col) -> hex code of the pressed key
//   low_row() - index of the lowest active-low row in a row sample
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hF;

  // Keypad legend, rows top to bottom, columns left to right:
  //   1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D   with * = E, # = F
  function automatic logic [3:0] map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Rows are active low; the lowest-numbered low row wins.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_hex_scanner_if.sv
// keypad_hex_scanner_if: keypad pins plus decoded-key outputs.
//   KEY_ROW   - rows from the keypad, active low
//   KEY_COL   - column strobes, active low
//   key_valid - one-cycle pulse per accepted key
//   key_code  - hex code of the last accepted key
//   key_held  - accepted key still down
//   num       - 16-bit entry register, newest digit in [3:0]
// master: the scanner; slave: keypad model / consumer side.
interface keypad_hex_scanner_if;
  logic [3:0]  KEY_ROW;
  logic [3:0]  KEY_COL;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] num;

  modport master (
    input  KEY_ROW,
    output KEY_COL, key_valid, key_code, key_held, num
  );

  modport slave (
    output KEY_ROW,
    input  KEY_COL, key_valid, key_code, key_held, num
  );
endinterface

// File: rtl/keypad_hex_scanner_key_sync.sv
// key_sync: 2-FF synchronizer for the four asynchronous keypad rows.
//   CP  - clock
//   RST - synchronous active-high reset (outputs idle high = no key)
//   d   - raw KEY_ROW
//   q   - synchronized rows
module key_sync (
  input  logic       CP,
  input  logic       RST,
  input  logic [3:0] d,
  output logic [3:0] q
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge CP) begin
      if (RST) begin
        meta_reg <= 1'b1;
        sync_reg <= 1'b1;
      end else begin
        meta_reg <= d[gi];
        sync_reg <= meta_reg;
      end
    end

    assign q[gi] = sync_reg;
  end

endmodule

// File: rtl/keypad_hex_scanner.sv
// keypad_hex_scanner: scans a 4x4 hex keypad, debounces presses and
// releases, decodes each accepted key and shifts it into a 16-bit entry
// register.
//   CP   - clock
//   RST  - synchronous active-high reset
//   kp   - keypad_hex_scanner_if.master (rows in; strobes, key outputs out)
// Parameters: SCAN_DIV (cycles per column, >= 4), DEBOUNCE_CNT (stable
// cycles to accept a press or release, >= 2).
// Build option: KEYPAD_CLEAR_KEY_EN - when defined, an accepted '#' (F)
// key clears num instead of shifting into it.
module keypad_hex_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic                  CP,
  input  logic                  RST,
  keypad_hex_scanner_if.master  kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CNT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

  logic [3:0] rs;

  key_sync u_sync (
    .CP  (CP),
    .RST (RST),
    .d   (kp.KEY_ROW),
    .q   (rs)
  );

  state_t           state_reg,     state_next;
  logic [1:0]       col_idx_reg,   col_idx_next;
  logic [1:0]       row_idx_reg,   row_idx_next;
  logic [3:0]       pat_reg,       pat_next;
  logic [DIV_W-1:0] div_cnt_reg,   div_cnt_next;
  logic [DEB_W-1:0] deb_cnt_reg,   deb_cnt_next;
  logic             key_valid_reg, key_valid_next;
  logic [3:0]       key_code_reg,  key_code_next;
  logic [15:0]      num_reg,       num_next;
  logic [3:0]       code_new;

  assign code_new = map(row_idx_reg, col_idx_reg);

  // State register
  always_ff @(posedge CP) begin
    if (RST) begin
      state_reg     <= SCAN;
      col_idx_reg   <= 2'd0;
      row_idx_reg   <= 2'd0;
      pat_reg       <= 4'hF;
      div_cnt_reg   <= '0;
      deb_cnt_reg   <= '0;
      key_valid_reg <= 1'b0;
      key_code_reg  <= 4'h0;
      num_reg       <= 16'h0000;
    end else begin
      state_reg     <= state_next;
      col_idx_reg   <= col_idx_next;
      row_idx_reg   <= row_idx_next;
      pat_reg       <= pat_next;
      div_cnt_reg   <= div_cnt_next;
      deb_cnt_reg   <= deb_cnt_next;
      key_valid_reg <= key_valid_next;
      key_code_reg  <= key_code_next;
      num_reg       <= num_next;
    end
  end

  // Next-state logic. Counters stop at their terminal value because every
  // terminal value causes a state change or an explicit clear.
  always_comb begin
    state_next     = state_reg;
    col_idx_next   = col_idx_reg;
    row_idx_next   = row_idx_reg;
    pat_next       = pat_reg;
    div_cnt_next   = div_cnt_reg;
    deb_cnt_next   = deb_cnt_reg;
    key_valid_next = 1'b0;
    key_code_next  = key_code_reg;
    num_next       = num_reg;

    case (state_reg)
      SCAN: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = '0;
          // Sample only on the last dwell cycle so the synchronizer has
          // settled on this column's rows.
          if (rs != 4'hF) begin
            state_next   = DEBOUNCE;
            pat_next     = rs;
            row_idx_next = low_row(rs);
            deb_cnt_next = '0;
          end else begin
            col_idx_next = col_idx_reg + 2'd1;
          end
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (rs != pat_reg) begin
          // Bounce: give up on this key and resume with the next column.
          state_next   = SCAN;
          col_idx_next = col_idx_reg + 2'd1;
          div_cnt_next = '0;
          deb_cnt_next = '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next     = PRESSED;
          deb_cnt_next   = '0;
          key_valid_next = 1'b1;
          key_code_next  = code_new;
`ifdef KEYPAD_CLEAR_KEY_EN
          if (code_new == KEY_CLEAR) num_next = 16'h0000;
          else                       num_next = {num_reg[11:0], code_new};
`else
          num_next = {num_reg[11:0], code_new};
`endif
        end else begin
          deb_cnt_next = deb_cnt_reg + 1'b1;
        end
      end

      PRESSED: begin
        // Column stays frozen, so other columns' keys are invisible here.
        if (rs == 4'hF) begin
          state_next   = RELEASE;
          deb_cnt_next = '0;
        end
      end

      RELEASE: begin
        if (rs != 4'hF) begin
          state_next   = PRESSED;
          deb_cnt_next = '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next   = SCAN;
          col_idx_next = 2'd0;
          div_cnt_next = '0;
          deb_cnt_next = '0;
        end else begin
          deb_cnt_next = deb_cnt_reg + 1'b1;
        end
      end

      default: state_next = SCAN;
    endcase
  end

  // Outputs
  always_comb begin
    kp.KEY_COL   = ~(4'b0001 << col_idx_reg);
    kp.key_held  = (state_reg == PRESSED) || (state_reg == RELEASE);
    kp.key_valid = key_valid_reg;
    kp.key_code  = key_code_reg;
    kp.num       = num_reg;
  end

endmodule

// File: tb/tb_keypad_hex_scanner.sv
module tb_keypad_hex_scanner;

  logic CP  = 1'b0;
  logic RST = 1'b1;
  always #5 CP = ~CP;

  keypad_hex_scanner_if kif ();

  keypad_hex_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (8)
  ) dut (
    .CP  (CP),
    .RST (RST),
    .kp  (kif)
  );

  // Keypad model: a pressed key (r,c) shorts row r to column strobe c.
  logic       pressed [4][4];
  logic [3:0] key_row;

  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && (kif.KEY_COL[c] == 1'b0)) key_row[r] = 1'b0;
  end

  assign kif.KEY_ROW = key_row;

  int checks    = 0;
  int errors    = 0;
  int pulse_cnt = 0;

  always @(negedge CP) if (kif.key_valid === 1'b1) pulse_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CP);
    #1;
  endtask

  task automatic clean_press(input int r, input int c, input int hold);
    pressed[r][c] = 1'b1;
    tick(hold);
    pressed[r][c] = 1'b0;
    tick(30);
    $display("press r%0d c%0d -> key_code %h num %h pulses %0d", r, c, kif.key_code, kif.num, pulse_cnt);
  endtask

  task automatic test_reset();
    logic [3:0] one_hot;
    logic [3:0] exp_col;
    RST = 1'b1;
    tick(3);
    @(negedge CP);
    checks++;
    if (kif.KEY_COL !== 4'b1110) begin errors++; $display("FAIL reset_col got %b want 1110", kif.KEY_COL); end
    checks++;
    if (kif.num !== 16'h0000) begin errors++; $display("FAIL reset_num got %h want 0000", kif.num); end
    checks++;
    if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", kif.key_valid); end
    checks++;
    if (kif.key_held !== 1'b0) begin errors++; $display("FAIL reset_held got %b want 0", kif.key_held); end
    checks++;
    if (kif.key_code !== 4'h0) begin errors++; $display("FAIL reset_code got %h want 0", kif.key_code); end
    RST = 1'b0;
    // Column k/4 (mod 4) is driven after the k-th edge out of reset.
    for (int k = 1; k <= 16; k++) begin
      @(negedge CP);
      one_hot = 4'b0001 << ((k / 4) % 4);
      exp_col = ~one_hot;
      checks++;
      if (kif.KEY_COL !== exp_col) begin
        errors++;
        $display("FAIL scan_col edge %0d got %b want %b", k, kif.KEY_COL, exp_col);
      end
    end
    $display("reset and idle scan done");
  endtask

  task automatic test_clean_press();
    int p0;
    int n;
    p0 = pulse_cnt;
    pressed[1][2] = 1'b1;
    tick(40);
    checks++;
    if (kif.key_held !== 1'b1) begin errors++; $display("FAIL press_held got %b want 1", kif.key_held); end
    pressed[1][2] = 1'b0;
    // 2 sync edges + 1 edge into RELEASE + 8 debounce edges
    n = 0;
    while (n < 50) begin
      @(negedge CP);
      n++;
      if (kif.key_held === 1'b0) break;
    end
    checks++;
    if (n < 10 || n > 12) begin errors++; $display("FAIL held_fall cycles got %0d want 10..12", n); end
    tick(20);
    checks++;
    if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL press_pulses got %0d want 1", pulse_cnt - p0); end
    checks++;
    if (kif.key_code !== 4'h6) begin errors++; $display("FAIL press_code got %h want 6", kif.key_code); end
    checks++;
    if (kif.num !== 16'h0006) begin errors++; $display("FAIL press_num got %h want 0006", kif.num); end
    $display("press r1 c2 -> key_code %h num %h", kif.key_code, kif.num);
  endtask

  task automatic test_sequence();
    int         rr [5] = '{0, 0, 0, 0, 1};
    int         cc [5] = '{0, 1, 2, 3, 1};
    logic [3:0] codes [5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h5};
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      clean_press(rr[i], cc[i], 40);
      checks++;
      if (kif.key_code !== codes[i]) begin
        errors++;
        $display("FAIL seq_code %0d got %h want %h", i, kif.key_code, codes[i]);
      end
    end
    checks++;
    if (kif.num !== 16'h23A5) begin errors++; $display("FAIL seq_num got %h want 23A5", kif.num); end
    checks++;
    if (pulse_cnt - p0 !== 5) begin errors++; $display("FAIL seq_pulses got %0d want 5", pulse_cnt - p0); end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < 20; i++) begin
      pressed[2][0] = (((i / 3) % 2) == 0);
      tick(1);
    end
    pressed[2][0] = 1'b1;
    tick(40);
    checks++;
    if (kif.key_held !== 1'b1) begin errors++; $display("FAIL bounce_held got %b want 1", kif.key_held); end
    for (int i = 0; i < 20; i++) begin
      pressed[2][0] = (((i / 3) % 2) == 1);
      tick(1);
    end
    pressed[2][0] = 1'b0;
    tick(30);
    checks++;
    if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL bounce_pulses got %0d want 1", pulse_cnt - p0); end
    checks++;
    if (kif.key_code !== 4'h7) begin errors++; $display("FAIL bounce_code got %h want 7", kif.key_code); end
    checks++;
    if (kif.num !== 16'h3A57) begin errors++; $display("FAIL bounce_num got %h want 3A57", kif.num); end
    $display("bounce r2 c0 -> key_code %h num %h", kif.key_code, kif.num);
  endtask

  task automatic test_multi_key();
    int p0;
    p0 = pulse_cnt;
    pressed[0][0] = 1'b1;
    tick(40);
    pressed[3][3] = 1'b1;
    tick(30);
    pressed[0][0] = 1'b0;
    pressed[3][3] = 1'b0;
    tick(30);
    checks++;
    if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL multi_pulses got %0d want 1", pulse_cnt - p0); end
    checks++;
    if (kif.key_code !== 4'h1) begin errors++; $display("FAIL multi_code got %h want 1", kif.key_code); end
    checks++;
    if (kif.num !== 16'hA571) begin errors++; $display("FAIL multi_num got %h want A571", kif.num); end
    $display("multi r0 c0 + r3 c3 -> key_code %h num %h", kif.key_code, kif.num);
  endtask

  task automatic test_clear_key();
    int p0;
    int n;
    logic [15:0] exp_num;
`ifdef KEYPAD_CLEAR_KEY_EN
    exp_num = 16'h0000;
`else
    exp_num = 16'h123F;
`endif
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    p0 = pulse_cnt;
    clean_press(0, 0, 40);
    clean_press(0, 1, 40);
    clean_press(0, 2, 40);
    checks++;
    if (kif.num !== 16'h0123) begin errors++; $display("FAIL clear_pre_num got %h want 0123", kif.num); end
    clean_press(3, 2, 40);
    checks++;
    if (kif.key_code !== 4'hF) begin errors++; $display("FAIL clear_code got %h want F", kif.key_code); end
    checks++;
    if (kif.num !== exp_num) begin errors++; $display("FAIL clear_num got %h want %h", kif.num, exp_num); end
    checks++;
    if (pulse_cnt - p0 !== 4) begin errors++; $display("FAIL clear_pulses got %0d want 4", pulse_cnt - p0); end

    // Reset while the '#' press is being debounced.
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    pressed[3][2] = 1'b1;
    p0 = pulse_cnt;
    n = 0;
    while (n < 40 && kif.KEY_COL !== 4'b1011) begin
      @(negedge CP);
      n++;
    end
    checks++;
    if (n >= 40) begin errors++; $display("FAIL rst_wait_col got %b want 1011", kif.KEY_COL); end
    tick(5);
    // Past the end of column 2's dwell: still on column 2 only if debouncing.
    checks++;
    if (kif.KEY_COL !== 4'b1011) begin errors++; $display("FAIL rst_frozen_col got %b want 1011", kif.KEY_COL); end
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    pressed[3][2] = 1'b0;
    tick(40);
    checks++;
    if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL rst_pulses got %0d want 0", pulse_cnt - p0); end
    checks++;
    if (kif.num !== 16'h0000) begin errors++; $display("FAIL rst_num got %h want 0000", kif.num); end
    checks++;
    if (kif.key_code !== 4'h0) begin errors++; $display("FAIL rst_code got %h want 0", kif.key_code); end
    checks++;
    if (kif.key_held !== 1'b0) begin errors++; $display("FAIL rst_held got %b want 0", kif.key_held); end
    $display("reset mid-debounce -> num %h pulses %0d", kif.num, pulse_cnt - p0);
  endtask

  initial begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pressed[r][c] = 1'b0;
    test_reset();
    test_clean_press();
    test_sequence();
    test_bounce();
    test_multi_key();
    test_clear_key();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
